// File: rtl/ddr3_sniffer_arbiter.sv
// Arbitrates the DDR3 user command port between the fabric (app) and OPB software requesters.
// Read returns are steered back to their issuer through an in-order owner-tag FIFO.
module ddr3_sniffer_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 128,
  parameter int unsigned SW_LOW_W  = 16,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst_n,
  input  logic                         phy_ready,
  input  logic [15:0]                  software_address_bits,
  input  logic                         sw_req,
  input  logic                         sw_rnw,
  input  logic [SW_LOW_W-1:0]          sw_addr,
  input  logic [DW-1:0]                sw_wdata,
  input  logic [DW/8-1:0]              sw_wmask,
  output logic                         sw_ack,
  output logic                         sw_rd_valid,
  output logic [DW-1:0]                sw_rd_data,
  input  logic                         app_req,
  input  logic                         app_rnw,
  input  logic [AW-1:0]                app_addr,
  input  logic [DW-1:0]                app_wdata,
  input  logic [DW/8-1:0]              app_wmask,
  output logic                         app_ack,
  output logic                         app_rd_valid,
  output logic [DW-1:0]                app_rd_data,
  output logic                         ddr_cmd_valid,
  output logic                         ddr_cmd_rnw,
  output logic [AW-1:0]                ddr_cmd_addr,
  output logic [DW-1:0]                ddr_wdata,
  output logic [DW/8-1:0]              ddr_wmask,
  input  logic                         ddr_cmd_ready,
  input  logic                         ddr_rd_valid,
  input  logic [DW-1:0]                ddr_rd_data,
  output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
  output logic                         err_unexpected_rd
);

  localparam int unsigned TW = $clog2(TAG_DEPTH);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 1: software, 0: app
  logic [BW-1:0]   burst_q, burst_d;
  logic            rnw_q, rnw_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;

  logic [TW:0]     cnt_q, cnt_d;
  logic [TW-1:0]   wp_q, rp_q;
  logic            tag_mem [TAG_DEPTH];
  logic            rd_tag;

  logic            app_rd_valid_q, sw_rd_valid_q, err_q;
  logic [DW-1:0]   app_rd_data_q, sw_rd_data_q;

  logic            can_read, app_elig, sw_elig, grant_app, grant_sw, push, pop;
  logic [AW-1:0]   sw_full_addr;

  always_comb begin
    sw_full_addr = '0;
    sw_full_addr[16+SW_LOW_W-1:0] = {software_address_bits, sw_addr};
  end

  // Eligibility uses the registered count, so a just-pushed tag is already accounted for.
  always_comb begin
    can_read  = cnt_q < (TW+1)'(TAG_DEPTH);
    app_elig  = app_req && (!app_rnw || can_read);
    sw_elig   = sw_req && (!sw_rnw || can_read);
    grant_app = 1'b0;
    grant_sw  = 1'b0;
    if (state_q == IDLE && phy_ready) begin
      if (sw_elig && (!app_elig || burst_q == BW'(MAX_BURST))) grant_sw = 1'b1;
      else if (app_elig)                                       grant_app = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (grant_sw) begin
          owner_d = 1'b1;
          rnw_d   = sw_rnw;
          addr_d  = sw_full_addr;
          wdata_d = sw_wdata;
          wmask_d = sw_wmask;
          state_d = ISSUE;
        end else if (grant_app) begin
          owner_d = 1'b0;
          rnw_d   = app_rnw;
          addr_d  = app_addr;
          wdata_d = app_wdata;
          wmask_d = app_wmask;
          state_d = ISSUE;
        end
      end
      ISSUE:   if (ddr_cmd_ready) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating so a blocked software read cannot overflow the counter.
  always_comb begin
    burst_d = burst_q;
    if (grant_sw || !sw_req)                          burst_d = '0;
    else if (grant_app && burst_q != BW'(MAX_BURST))  burst_d = burst_q + BW'(1);
  end

  always_comb begin
    push   = (state_q == ISSUE) && ddr_cmd_ready && rnw_q;
    pop    = ddr_rd_valid && (cnt_q != '0);
    rd_tag = tag_mem[rp_q];
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (TW+1)'(1);
      2'b01:   cnt_d = cnt_q - (TW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      burst_q        <= '0;
      rnw_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      cnt_q          <= '0;
      wp_q           <= '0;
      rp_q           <= '0;
      app_rd_valid_q <= 1'b0;
      sw_rd_valid_q  <= 1'b0;
      app_rd_data_q  <= '0;
      sw_rd_data_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      burst_q        <= burst_d;
      rnw_q          <= rnw_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wmask_q        <= wmask_d;
      cnt_q          <= cnt_d;
      if (push) wp_q <= wp_q + TW'(1);
      if (pop)  rp_q <= rp_q + TW'(1);
      app_rd_valid_q <= pop && !rd_tag;
      sw_rd_valid_q  <= pop && rd_tag;
      if (pop && !rd_tag) app_rd_data_q <= ddr_rd_data;
      if (pop && rd_tag)  sw_rd_data_q  <= ddr_rd_data;
      if (ddr_rd_valid && cnt_q == '0) err_q <= 1'b1;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (push) tag_mem[wp_q] <= owner_q;
  end

  assign ddr_cmd_valid     = (state_q == ISSUE);
  assign ddr_cmd_rnw       = rnw_q;
  assign ddr_cmd_addr      = addr_q;
  assign ddr_wdata         = wdata_q;
  assign ddr_wmask         = wmask_q;
  assign app_ack           = (state_q == ACK) && !owner_q;
  assign sw_ack            = (state_q == ACK) && owner_q;
  assign app_rd_valid      = app_rd_valid_q;
  assign sw_rd_valid       = sw_rd_valid_q;
  assign app_rd_data       = app_rd_data_q;
  assign sw_rd_data        = sw_rd_data_q;
  assign rd_outstanding    = cnt_q;
  assign err_unexpected_rd = err_q;

endmodule

// File: tb/tb_ddr3_sniffer_arbiter.sv
// Directed self-checking bench for ddr3_sniffer_arbiter: grants, address extension,
// burst fairness, read routing, tag-full backpressure, unexpected data and async reset.
module tb_ddr3_sniffer_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          phy_ready;
  logic [15:0]   software_address_bits;
  logic          sw_req, sw_rnw;
  logic [15:0]   sw_addr;
  logic [127:0]  sw_wdata;
  logic [15:0]   sw_wmask;
  logic          sw_ack, sw_rd_valid;
  logic [127:0]  sw_rd_data;
  logic          app_req, app_rnw;
  logic [31:0]   app_addr;
  logic [127:0]  app_wdata;
  logic [15:0]   app_wmask;
  logic          app_ack, app_rd_valid;
  logic [127:0]  app_rd_data;
  logic          ddr_cmd_valid, ddr_cmd_rnw;
  logic [31:0]   ddr_cmd_addr;
  logic [127:0]  ddr_wdata;
  logic [15:0]   ddr_wmask;
  logic          ddr_cmd_ready;
  logic          ddr_rd_valid;
  logic [127:0]  ddr_rd_data;
  logic [4:0]    rd_outstanding;
  logic          err_unexpected_rd;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ddr3_sniffer_arbiter #(
    .AW(32), .DW(128), .SW_LOW_W(16), .MAX_BURST(8), .TAG_DEPTH(16)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .phy_ready(phy_ready),
    .software_address_bits(software_address_bits),
    .sw_req(sw_req), .sw_rnw(sw_rnw), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_wmask(sw_wmask), .sw_ack(sw_ack), .sw_rd_valid(sw_rd_valid), .sw_rd_data(sw_rd_data),
    .app_req(app_req), .app_rnw(app_rnw), .app_addr(app_addr), .app_wdata(app_wdata),
    .app_wmask(app_wmask), .app_ack(app_ack), .app_rd_valid(app_rd_valid),
    .app_rd_data(app_rd_data),
    .ddr_cmd_valid(ddr_cmd_valid), .ddr_cmd_rnw(ddr_cmd_rnw), .ddr_cmd_addr(ddr_cmd_addr),
    .ddr_wdata(ddr_wdata), .ddr_wmask(ddr_wmask), .ddr_cmd_ready(ddr_cmd_ready),
    .ddr_rd_valid(ddr_rd_valid), .ddr_rd_data(ddr_rd_data),
    .rd_outstanding(rd_outstanding), .err_unexpected_rd(err_unexpected_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete command from an idle arbiter with ddr_cmd_ready already high.
  task automatic do_cmd(input logic is_sw, input logic rnw);
    if (is_sw) begin sw_req = 1'b1; sw_rnw = rnw; end
    else       begin app_req = 1'b1; app_rnw = rnw; end
    tick();
    tick();
    check(is_sw ? "cmd_sw_ack" : "cmd_app_ack", 128'(is_sw ? sw_ack : app_ack), 128'd1);
    sw_req  = 1'b0;
    app_req = 1'b0;
    tick();
  endtask

  logic [31:0]  hold_addr;
  logic [127:0] hold_wdata;

  initial begin
    rst_n = 1'b0; phy_ready = 1'b0; ddr_cmd_ready = 1'b0;
    ddr_rd_valid = 1'b0; ddr_rd_data = '0;
    software_address_bits = '0; sw_req = 1'b0; sw_rnw = 1'b0; sw_addr = '0;
    sw_wdata = '0; sw_wmask = '0;
    app_req = 1'b1; app_rnw = 1'b0; app_addr = 32'h1000_0040;
    app_wdata = 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0; app_wmask = 16'h00FF;

    #12;
    check("rst_cmd_valid", 128'(ddr_cmd_valid), 128'd0);
    check("rst_cmd_addr", 128'(ddr_cmd_addr), 128'd0);
    check("rst_app_ack", 128'(app_ack), 128'd0);
    check("rst_outstanding", 128'(rd_outstanding), 128'd0);
    check("rst_err", 128'(err_unexpected_rd), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic accept gated by phy_ready
    tick(); tick();
    check("no_grant_phy_low", 128'(ddr_cmd_valid), 128'd0);
    phy_ready = 1'b1;
    tick();
    check("basic_valid", 128'(ddr_cmd_valid), 128'd1);
    check("basic_addr", 128'(ddr_cmd_addr), 128'h1000_0040);
    check("basic_wmask", 128'(ddr_wmask), 128'h00FF);
    check("basic_wdata", ddr_wdata, 128'hAAAA_5555_0000_FFFF_1234_5678_9ABC_DEF0);
    ddr_cmd_ready = 1'b1;
    tick();
    check("basic_app_ack", 128'(app_ack), 128'd1);
    check("basic_valid_drop", 128'(ddr_cmd_valid), 128'd0);
    app_req = 1'b0;
    tick();
    check("basic_ack_pulse", 128'(app_ack), 128'd0);

    // Address extension
    software_address_bits = 16'h00A5; sw_addr = 16'h1234; sw_rnw = 1'b0;
    sw_wmask = 16'hF0F0; sw_wdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    sw_req = 1'b1;
    tick();
    check("ext_addr", 128'(ddr_cmd_addr), 128'h00A5_1234);
    check("ext_rnw", 128'(ddr_cmd_rnw), 128'd0);
    check("ext_wmask", 128'(ddr_wmask), 128'hF0F0);
    check("ext_wdata", ddr_wdata, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    tick();
    check("ext_sw_ack", 128'(sw_ack), 128'd1);
    check("ext_app_ack", 128'(app_ack), 128'd0);
    sw_req = 1'b0;
    tick();

    // Burst limit: 8 app grants then 1 software, repeating
    app_req = 1'b1; app_rnw = 1'b0; sw_req = 1'b1; sw_rnw = 1'b0;
    for (int g = 0; g < 18; g++) begin
      tick();
      tick();
      check("burst_app_ack", 128'(app_ack), 128'((g % 9) != 8));
      check("burst_sw_ack", 128'(sw_ack), 128'((g % 9) == 8));
      tick();
    end
    app_req = 1'b0; sw_req = 1'b0;
    tick();

    // Read routing app, sw, app
    do_cmd(1'b0, 1'b1);
    do_cmd(1'b1, 1'b1);
    do_cmd(1'b0, 1'b1);
    check("route_outstanding3", 128'(rd_outstanding), 128'd3);
    ddr_rd_valid = 1'b1; ddr_rd_data = 128'hD0;
    tick();
    check("route0_app_valid", 128'(app_rd_valid), 128'd1);
    check("route0_sw_valid", 128'(sw_rd_valid), 128'd0);
    check("route0_app_data", app_rd_data, 128'hD0);
    check("route0_outstanding", 128'(rd_outstanding), 128'd2);
    ddr_rd_data = 128'hD1;
    tick();
    check("route1_sw_valid", 128'(sw_rd_valid), 128'd1);
    check("route1_app_valid", 128'(app_rd_valid), 128'd0);
    check("route1_sw_data", sw_rd_data, 128'hD1);
    check("route1_app_hold", app_rd_data, 128'hD0);
    ddr_rd_data = 128'hD2;
    tick();
    check("route2_app_valid", 128'(app_rd_valid), 128'd1);
    check("route2_app_data", app_rd_data, 128'hD2);
    check("route2_sw_hold", sw_rd_data, 128'hD1);
    check("route2_outstanding", 128'(rd_outstanding), 128'd0);
    ddr_rd_valid = 1'b0;
    tick();
    check("route_valid_pulse", 128'(app_rd_valid), 128'd0);

    // Tag full: 17th app read blocked while the software write proceeds
    for (int i = 0; i < 16; i++) do_cmd(1'b0, 1'b1);
    check("full_outstanding", 128'(rd_outstanding), 128'd16);
    app_req = 1'b1; app_rnw = 1'b1; app_addr = 32'h2000_0000;
    sw_req = 1'b1; sw_rnw = 1'b0; sw_addr = 16'hBEEF; software_address_bits = 16'h0012;
    sw_wdata = 128'hCAFE;
    ddr_cmd_ready = 1'b0;
    tick();
    check("full_valid", 128'(ddr_cmd_valid), 128'd1);
    check("full_sw_write_rnw", 128'(ddr_cmd_rnw), 128'd0);
    check("full_sw_addr", 128'(ddr_cmd_addr), 128'h0012_BEEF);
    hold_addr = ddr_cmd_addr;
    hold_wdata = ddr_wdata;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) phy_ready = 1'b0;
      tick();
      check("bp_valid", 128'(ddr_cmd_valid), 128'd1);
      check("bp_addr", 128'(ddr_cmd_addr), 128'h0012_BEEF);
      check("bp_wdata", ddr_wdata, 128'hCAFE);
    end
    ddr_cmd_ready = 1'b1;
    tick();
    check("bp_sw_ack", 128'(sw_ack), 128'd1);
    check("bp_app_ack", 128'(app_ack), 128'd0);
    sw_req = 1'b0; phy_ready = 1'b1;
    tick();
    tick();
    check("full_no_read_grant", 128'(ddr_cmd_valid), 128'd0);
    tick();
    check("full_no_read_grant2", 128'(ddr_cmd_valid), 128'd0);
    app_req = 1'b0;

    // Drain 16 returns; exercises pointer wrap
    ddr_rd_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ddr_rd_data = 128'(i + 100);
      tick();
      check("drain_app_valid", 128'(app_rd_valid), 128'd1);
      check("drain_app_data", app_rd_data, 128'(i + 100));
    end
    ddr_rd_valid = 1'b0;
    check("drain_outstanding", 128'(rd_outstanding), 128'd0);
    tick();

    // Unexpected read data
    ddr_rd_valid = 1'b1; ddr_rd_data = 128'hBAD;
    tick();
    check("unexp_err", 128'(err_unexpected_rd), 128'd1);
    check("unexp_app_valid", 128'(app_rd_valid), 128'd0);
    check("unexp_sw_valid", 128'(sw_rd_valid), 128'd0);
    check("unexp_outstanding", 128'(rd_outstanding), 128'd0);
    ddr_rd_valid = 1'b0;
    tick();

    // Async reset in ISSUE with a read tag outstanding
    do_cmd(1'b0, 1'b1);
    check("pre_rst_outstanding", 128'(rd_outstanding), 128'd1);
    app_req = 1'b1; app_rnw = 1'b0; app_addr = 32'h3333_0000;
    ddr_cmd_ready = 1'b0;
    tick();
    check("pre_rst_valid", 128'(ddr_cmd_valid), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(ddr_cmd_valid), 128'd0);
    check("arst_addr", 128'(ddr_cmd_addr), 128'd0);
    check("arst_wdata", ddr_wdata, 128'd0);
    check("arst_outstanding", 128'(rd_outstanding), 128'd0);
    check("arst_err", 128'(err_unexpected_rd), 128'd0);
    check("arst_app_data", app_rd_data, 128'd0);
    check("arst_sw_data", sw_rd_data, 128'd0);
    app_req = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    tick();
    ddr_rd_valid = 1'b1; ddr_rd_data = 128'h55;
    tick();
    check("post_rst_err", 128'(err_unexpected_rd), 128'd1);
    check("post_rst_app_valid", 128'(app_rd_valid), 128'd0);
    ddr_rd_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr3_sniffer_arbiter.md
# ddr3_sniffer_arbiter

Shares the single DDR3 user command/data port between the fabric application requester and the software (OPB) requester. It sits between the OPB sniffer attachment, which supplies `software_address_bits` and `phy_ready`, and the DDR3 controller user interface. Software addresses are extended with the software-controlled MSBs. Read returns are routed back to the issuing requester through an in-order owner-tag FIFO.

## Interface
- `AW`, 32: DDR3 command address width; must be ≥ 16 + `SW_LOW_W`.
- `DW`, 128: data width; mask width is `DW/8`.
- `SW_LOW_W`, 16: width of the software-side low address.
- `MAX_BURST`, 8: maximum consecutive app grants while `sw_req` is pending.
- `TAG_DEPTH`, 16: maximum outstanding reads; power of 2.
- `OPB_Clk`  in  1  single clock for the whole block.
- `OPB_Rst_n`  in  1  asynchronous, active-low reset.
- `phy_ready`  in  1  DDR3 PHY calibrated; gates new grants.
- `software_address_bits`  in  16  software-controlled DDR3 address MSBs.
- `sw_req`, `sw_rnw`  in  1  software request and read-not-write.
- `sw_addr`  in  `SW_LOW_W`  software low address.
- `sw_wdata`  in  `DW`; `sw_wmask`  in  `DW/8`  software write data and mask.
- `sw_ack`  out  1  one-cycle pulse; software command accepted.
- `sw_rd_valid`  out  1; `sw_rd_data`  out  `DW`  software read return.
- `app_req`, `app_rnw`  in  1; `app_addr`  in  `AW`; `app_wdata`  in  `DW`; `app_wmask`  in  `DW/8`  fabric request.
- `app_ack`  out  1; `app_rd_valid`  out  1; `app_rd_data`  out  `DW`  fabric accept and read return.
- `ddr_cmd_valid`, `ddr_cmd_rnw`  out  1; `ddr_cmd_addr`  out  `AW`; `ddr_wdata`  out  `DW`; `ddr_wmask`  out  `DW/8`  command to the controller.
- `ddr_cmd_ready`  in  1  controller accepts the command.
- `ddr_rd_valid`  in  1; `ddr_rd_data`  in  `DW`  in-order read data from the controller.
- `rd_outstanding`  out  `log2(TAG_DEPTH)+1`  count of outstanding reads.
- `err_unexpected_rd`  out  1  sticky; set when read data arrives with no tag outstanding.

## Operation
- FSM states: IDLE, ISSUE, ACK. Reset state is IDLE.
- **IDLE.** A requester is eligible when its `req` is high and either it is a write or `rd_outstanding < TAG_DEPTH`. No grant is made while `phy_ready` is 0.
- **Priority.** App wins by default. If `burst_cnt == MAX_BURST` and software is eligible, software wins. Software never receives two consecutive grants while app is eligible.
- **burst_cnt.** Increments on each app grant while `sw_req` is high. Clears on a software grant and whenever `sw_req` is low.
- **Latching.** On grant, the command fields and owner are latched, and the FSM goes to ISSUE.
- **Address.** Software command address = zero-extend(`{software_address_bits, sw_addr}`) to `AW`. App address is passed through unchanged.
- **ISSUE.** `ddr_cmd_valid` = 1 and all command fields are held stable until `ddr_cmd_ready` = 1. It is never aborted: a `phy_ready` drop here does not withdraw the command. On the handshake, a read pushes its owner tag into the FIFO. Next state is ACK.
- **ACK.** Asserts the owner's `ack` for exactly one cycle, then returns to IDLE.
- **Requester contract.** Hold `req` and the fields until `ack`. Drop `req` (or present a new request) from the cycle after `ack`.
- **Read return.** On `ddr_rd_valid`, pop the head tag. Register `ddr_rd_data` to the owner's `rd_data`. Pulse the owner's `rd_valid` for one cycle.
- **Unexpected data.** If the FIFO is empty on `ddr_rd_valid`, drop the data, pulse no `rd_valid`, and set `err_unexpected_rd`. It clears only on reset.
- **Counter.** Push and pop in the same cycle leave `rd_outstanding` unchanged. The FIFO pointers wrap modulo `TAG_DEPTH`.
- **Non-owner data.** The non-owner's `rd_data` holds its last value.

## Timing
- **Reset.** Every output resets to 0: acks, `rd_valid`s, `rd_data`s, all `ddr_*` outputs, `rd_outstanding`, `err_unexpected_rd`. FSM is IDLE, FIFO is empty, `burst_cnt` = 0.
- **Reset mid-operation.** Any in-flight command and all tags are lost. Subsequent `ddr_rd_valid` pulses set `err_unexpected_rd`.
- **Command path.** `req` sampled high in IDLE at cycle 0 → `ddr_cmd_valid` high at cycle 1. With `ddr_cmd_ready` = 1: handshake at cycle 1, `ack` at cycle 2, IDLE at cycle 3.
- **Throughput.** Peak is one command per 3 cycles.
- **Read data latency.** `ddr_rd_valid` at cycle n → owner `rd_valid`/`rd_data` at cycle n+1.
- **Counter timing.** `rd_outstanding` updates the cycle after a push or pop. The read-eligibility check uses the registered count.
- **Same-cycle push/pop.** A tag pushed in a handshake cycle can be popped no earlier than the following cycle.

## Test plan
- **Basic accept.** Reset with `phy_ready` = 0, `app_req` = 1 → no `ddr_cmd_valid`. Raise `phy_ready` → `ddr_cmd_valid` 1 cycle later, then `app_ack` 1 cycle after `ddr_cmd_ready`.
- **Address extension.** `software_address_bits` = 0x00A5, `sw_addr` = 0x1234, software write → `ddr_cmd_addr` = 0x00A51234, `ddr_cmd_rnw` = 0, mask passed unchanged.
- **Burst limit.** `app_req` and `sw_req` held continuously, `MAX_BURST` = 8 → grant order is 8 app, 1 software, repeating. Neither `ack` is ever lost.
- **Read routing.** Three reads issued as app, software, app, then three `ddr_rd_valid` with data D0/D1/D2 → `app_rd_valid`(D0), `sw_rd_valid`(D1), `app_rd_valid`(D2). `rd_outstanding` goes 3 → 0.
- **Tag full and backpressure.** Issue 16 reads with no returns → a 17th read is not granted while a write from the other port is granted. Hold `ddr_cmd_ready` low 5 cycles → command fields stay stable. Drop `phy_ready` in ISSUE → the command still completes.
- **Error and reset.** `ddr_rd_valid` with the FIFO empty → `err_unexpected_rd` = 1 and no `rd_valid`. Assert `OPB_Rst_n` = 0 mid-ISSUE → all outputs 0 immediately, with no clock edge needed.
